// File: rtl/econet_fcs_pkg.sv
// Shared types, CRC-16 HDLC constants and the reflected one-byte CRC update
// used by the Econet FCS engine.
package econet_fcs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_APPEND = 2'd2,
        ST_DONE   = 2'd3
    } fcs_state_e;

    localparam int          MAX_WIDTH     = 32;
    localparam logic [15:0] CRC16_POLY    = 16'h8408;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'hF0B8;

    // Reflected update: bit 0 of the byte goes first, so the register shifts
    // right and the polynomial is folded in when the outgoing bit disagrees.
    function automatic logic [MAX_WIDTH-1:0] fcs_step(
        input logic [MAX_WIDTH-1:0] crc,
        input logic [7:0]           data,
        input logic [MAX_WIDTH-1:0] poly,
        input int                   width
    );
        logic [MAX_WIDTH-1:0] c;
        logic [MAX_WIDTH-1:0] mask;
        mask = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
        c    = crc & mask;
        for (int i = 0; i < 8; i++) begin
            if (c[0] != data[i]) c = (c >> 1) ^ (poly & mask);
            else                 c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/econet_fcs_step.sv
// Combinational one-byte CRC update for a given width and reflected polynomial.
module econet_fcs_step
    import econet_fcs_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = CRC16_POLY
) (
    input  logic [WIDTH-1:0] crc,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] crc_next
);

    assign crc_next = WIDTH'(fcs_step(MAX_WIDTH'(crc), data, MAX_WIDTH'(POLY), WIDTH));

endmodule

// File: rtl/econet_fcs_engine.sv
// Byte-serial Econet FCS engine: checks received frames against the residue,
// or appends the complemented FCS (LSB byte first) to transmitted frames.
module econet_fcs_engine
    import econet_fcs_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] POLY    = CRC16_POLY,
    parameter logic [WIDTH-1:0] INIT    = '1,
    parameter logic [WIDTH-1:0] RESIDUE = CRC16_RESIDUE,
    parameter logic [WIDTH-1:0] XOROUT  = '1
) (
    input  logic             econet_clk,
    input  logic             reset_n,
    input  logic             sof,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] fcs_value,
    output logic             done,
    output logic             fcs_ok
);

    localparam int NBYTES = WIDTH / 8;

    fcs_state_e       state;
    logic             mode_q;
    logic [1:0]       idx;
    logic [WIDTH-1:0] tx_fcs;
    logic [WIDTH-1:0] crc_next;

    econet_fcs_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .crc      (fcs_value),
        .data     (in_data),
        .crc_next (crc_next)
    );

    assign in_ready = (state == ST_ACCUM);

    always_ff @(posedge econet_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            fcs_value <= INIT;
            mode_q    <= 1'b0;
            idx       <= '0;
            tx_fcs    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            fcs_ok    <= 1'b0;
        end else if (sof) begin
            // A new frame wins over everything, including a byte offered alongside it.
            state     <= ST_ACCUM;
            fcs_value <= INIT;
            mode_q    <= mode;
            fcs_ok    <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        fcs_value <= crc_next;
                        if (in_last) begin
                            if (mode_q) begin
                                tx_fcs    <= crc_next ^ XOROUT;
                                out_data  <= 8'(crc_next ^ XOROUT);
                                out_valid <= 1'b1;
                                idx       <= '0;
                                state     <= ST_APPEND;
                            end else begin
                                fcs_ok <= (crc_next == RESIDUE);
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                        end
                    end
                end
                ST_APPEND: begin
                    if (out_ready) begin
                        if (idx == 2'(NBYTES - 1)) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            idx      <= idx + 2'd1;
                            out_data <= 8'(tx_fcs >> (8 * (int'(idx) + 1)));
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_econet_fcs_engine.sv
// Drives a CRC-16 and a CRC-32 engine with the same byte stream and compares
// both every cycle against a frame-level model.
module tb_econet_fcs_engine;

    logic        econet_clk = 1'b0;
    logic        reset_n    = 1'b0;
    logic        sof        = 1'b0;
    logic        mode       = 1'b0;
    logic        in_valid   = 1'b0;
    logic        in_last    = 1'b0;
    logic        out_ready  = 1'b0;
    logic [7:0]  in_data    = 8'h00;

    logic        rdy16, ov16, done16, ok16;
    logic        rdy32, ov32, done32, ok32;
    logic [7:0]  od16, od32;
    logic [15:0] fv16;
    logic [31:0] fv32;

    int nchecks = 0;
    int nerrors = 0;
    int or_mode = 0;

    always #5 econet_clk = ~econet_clk;

    econet_fcs_engine dut16 (
        .econet_clk (econet_clk), .reset_n (reset_n), .sof (sof), .mode (mode),
        .in_valid (in_valid), .in_data (in_data), .in_last (in_last), .in_ready (rdy16),
        .out_valid (ov16), .out_data (od16), .out_ready (out_ready),
        .fcs_value (fv16), .done (done16), .fcs_ok (ok16)
    );

    econet_fcs_engine #(
        .WIDTH (32), .POLY (32'hEDB88320), .INIT (32'hFFFFFFFF),
        .RESIDUE (32'hDEBB20E3), .XOROUT (32'hFFFFFFFF)
    ) dut32 (
        .econet_clk (econet_clk), .reset_n (reset_n), .sof (sof), .mode (mode),
        .in_valid (in_valid), .in_data (in_data), .in_last (in_last), .in_ready (rdy32),
        .out_valid (ov32), .out_data (od32), .out_ready (out_ready),
        .fcs_value (fv32), .done (done32), .fcs_ok (ok32)
    );

    // index 0 = CRC-16 engine, index 1 = CRC-32 engine
    int          WB[2] = '{16, 32};
    logic [31:0] PL[2] = '{32'h00008408, 32'hEDB88320};
    logic [31:0] RS[2] = '{32'h0000F0B8, 32'hDEBB20E3};
    logic [31:0] MK[2] = '{32'h0000FFFF, 32'hFFFFFFFF};

    logic        a_rdy[2], a_ov[2], a_dn[2], a_ok[2];
    logic [7:0]  a_od[2];
    logic [31:0] a_fv[2];
    assign a_rdy[0] = rdy16;  assign a_rdy[1] = rdy32;
    assign a_ov[0]  = ov16;   assign a_ov[1]  = ov32;
    assign a_dn[0]  = done16; assign a_dn[1]  = done32;
    assign a_ok[0]  = ok16;   assign a_ok[1]  = ok32;
    assign a_od[0]  = od16;   assign a_od[1]  = od32;
    assign a_fv[0]  = {16'h0000, fv16};
    assign a_fv[1]  = fv32;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Table-free byte-at-a-time reflected CRC: fold the byte in, then divide.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b, input int d);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ PL[d]) : (r >> 1);
        return r;
    endfunction

    logic [7:0] fr[$];

    function automatic logic [31:0] crc_of_fr(input int d);
        logic [31:0] r;
        r = MK[d];
        foreach (fr[i]) r = crc_byte(r, fr[i], d);
        return r;
    endfunction

    // ---------------- frame-level model ----------------
    bit          m_acc[2], m_mode[2], m_ok[2], m_done[2];
    logic [31:0] m_crc[2];
    logic [31:0] m_f;
    logic [7:0]  m_tx[2][4];
    int          m_cnt[2], m_pos[2];

    always @(posedge econet_clk or negedge reset_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_acc[d] = 0; m_mode[d] = 0; m_ok[d] = 0; m_done[d] = 0;
                m_crc[d] = MK[d]; m_cnt[d] = 0; m_pos[d] = 0;
            end else begin
                m_done[d] = 0;
                if (sof) begin
                    m_crc[d] = MK[d]; m_mode[d] = mode; m_ok[d] = 0;
                    m_acc[d] = 1; m_cnt[d] = 0; m_pos[d] = 0;
                end else if (m_pos[d] < m_cnt[d]) begin
                    if (out_ready) begin
                        m_pos[d]++;
                        if (m_pos[d] == m_cnt[d]) m_done[d] = 1;
                    end
                end else if (m_acc[d] && in_valid) begin
                    m_crc[d] = crc_byte(m_crc[d], in_data, d);
                    if (in_last) begin
                        m_acc[d] = 0;
                        if (m_mode[d]) begin
                            m_f = m_crc[d] ^ MK[d];
                            for (int k = 0; k < WB[d] / 8; k++) m_tx[d][k] = m_f[8*k +: 8];
                            m_cnt[d] = WB[d] / 8;
                            m_pos[d] = 0;
                        end else begin
                            m_ok[d]   = (m_crc[d] == RS[d]);
                            m_done[d] = 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge econet_clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("in_ready_w%0d", WB[d]), a_rdy[d], m_acc[d]);
            chk($sformatf("out_valid_w%0d", WB[d]), a_ov[d], m_pos[d] < m_cnt[d]);
            if (m_pos[d] < m_cnt[d])
                chk($sformatf("out_data_w%0d", WB[d]), a_od[d], m_tx[d][m_pos[d]]);
            chk($sformatf("fcs_value_w%0d", WB[d]), a_fv[d], m_crc[d]);
            chk($sformatf("done_w%0d", WB[d]), a_dn[d], m_done[d]);
            chk($sformatf("fcs_ok_w%0d", WB[d]), a_ok[d], m_ok[d]);
        end
    end

    // transfer and done logs for the directed literal checks
    logic [7:0] xq16[$], xq32[$];
    int dc16 = 0, dc32 = 0;
    always @(posedge econet_clk) begin
        if (reset_n) begin
            if (ov16 && out_ready) xq16.push_back(od16);
            if (ov32 && out_ready) xq32.push_back(od32);
            if (done16) dc16++;
            if (done32) dc32++;
        end
    end

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge econet_clk);
            c++;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                2:       out_ready = (c % 4 == 3);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic start_frame(input bit md);
        sof = 1'b1; mode = md;
        in_valid = ($urandom_range(0, 1) == 1);   // must be discarded
        in_data  = 8'($urandom);
        in_last  = ($urandom_range(0, 1) == 1);
        @(negedge econet_clk);
        sof = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b, input logic l);
        int t;
        t = 0;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge econet_clk);
        end
        in_valid = 1'b1; in_data = b; in_last = l;
        while (!rdy16 && t < 50) begin
            @(negedge econet_clk);
            t++;
        end
        chk("accept_timeout", t >= 50, 0);
        @(negedge econet_clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic put_bytes(input int n);
        for (int i = 0; i < n; i++) put_byte(fr[i], i == fr.size() - 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (t < 200 && (m_acc[0] || m_acc[1] || m_pos[0] < m_cnt[0] ||
                           m_pos[1] < m_cnt[1] || m_done[0] || m_done[1])) begin
            @(negedge econet_clk);
            t++;
        end
        chk("idle_timeout", t >= 200, 0);
        @(negedge econet_clk);
    endtask

    task automatic load_check_string();
        fr.delete();
        for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    endtask

    int b16, b32, d16, d32;

    initial begin
        int n, k;
        logic [31:0] f;

        repeat (2) @(negedge econet_clk);
        chk("rst_fcs16", fv16, 16'hFFFF);
        chk("rst_fcs32", fv32, 32'hFFFFFFFF);
        chk("rst_in_ready", rdy16, 0);
        chk("rst_out_valid", ov16, 0);
        chk("rst_out_data", od16, 8'h00);
        chk("rst_done", done16, 0);
        chk("rst_fcs_ok", ok16, 0);

        load_check_string();
        chk("model_pin16", crc_of_fr(0), 32'h00006F91);
        chk("model_pin32", crc_of_fr(1), 32'h340BC6D9);
        reset_n = 1'b1;
        @(negedge econet_clk);

        // transmit "123456789", out_ready high
        or_mode = 0;
        b16 = xq16.size(); b32 = xq32.size(); d16 = dc16; d32 = dc32;
        start_frame(1); put_bytes(9); wait_idle();
        chk("tx_fcs16", fv16, 16'h6F91);
        chk("tx_fcs32", fv32, 32'h340BC6D9);
        chk("tx_count16", xq16.size() - b16, 2);
        chk("tx16_b0", xq16[b16], 8'h6E);
        chk("tx16_b1", xq16[b16+1], 8'h90);
        chk("tx_count32", xq32.size() - b32, 4);
        chk("tx32_b0", xq32[b32], 8'h26);
        chk("tx32_b1", xq32[b32+1], 8'h39);
        chk("tx32_b2", xq32[b32+2], 8'hF4);
        chk("tx32_b3", xq32[b32+3], 8'hCB);
        chk("tx_done16", dc16 - d16, 1);
        chk("tx_done32", dc32 - d32, 1);

        // receive with good FCS-16
        fr.push_back(8'h6E); fr.push_back(8'h90);
        d16 = dc16;
        start_frame(0); put_bytes(11); wait_idle();
        chk("rx_ok16", ok16, 1);
        chk("rx_fcs16", fv16, 16'hF0B8);
        chk("rx_done16", dc16 - d16, 1);

        // corrupted byte 3
        fr[2] = 8'h32;
        d16 = dc16;
        start_frame(0); put_bytes(11); wait_idle();
        chk("rx_bad_ok16", ok16, 0);
        chk("rx_bad_done16", dc16 - d16, 1);
        fr[2] = 8'h33;

        // transmit with out_ready low 3 cycles per byte
        load_check_string();
        or_mode = 2;
        b16 = xq16.size(); d16 = dc16;
        start_frame(1); put_bytes(9); wait_idle();
        chk("tx_slow_count16", xq16.size() - b16, 2);
        chk("tx_slow_b0", xq16[b16], 8'h6E);
        chk("tx_slow_b1", xq16[b16+1], 8'h90);
        chk("tx_slow_done16", dc16 - d16, 1);
        or_mode = 0;

        // abort after 4 bytes, then a fresh good receive frame
        fr.push_back(8'h6E); fr.push_back(8'h90);
        d16 = dc16;
        start_frame(0); put_bytes(4);
        start_frame(0); put_bytes(11); wait_idle();
        chk("abort_done16", dc16 - d16, 1);
        chk("abort_ok16", ok16, 1);

        // receive with good FCS-32
        load_check_string();
        fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
        start_frame(0); put_bytes(13); wait_idle();
        chk("rx_ok32", ok32, 1);
        chk("rx_fcs32", fv32, 32'hDEBB20E3);

        // reset pulsed mid-append
        load_check_string();
        or_mode = 3;
        start_frame(1); put_bytes(9);
        repeat (2) @(negedge econet_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid16", ov16, 0);
        chk("mid_rst_out_valid32", ov32, 0);
        chk("mid_rst_out_data16", od16, 8'h00);
        chk("mid_rst_fcs16", fv16, 16'hFFFF);
        chk("mid_rst_fcs32", fv32, 32'hFFFFFFFF);
        chk("mid_rst_done", done16, 0);
        @(negedge econet_clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom); in_last = ($urandom_range(0, 1) == 1);
            @(negedge econet_clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("post_rst_fcs16", fv16, 16'hFFFF);
        chk("post_rst_in_ready", rdy16, 0);
        or_mode = 1;

        // randomized frames
        repeat (60) begin
            or_mode = $urandom_range(0, 2);
            n = $urandom_range(1, 10);
            fr.delete();
            for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
            if ($urandom_range(0, 5) == 0 && n >= 2) begin
                k = $urandom_range(1, n - 1);
                start_frame($urandom_range(0, 1) == 1);
                put_bytes(k);
            end
            if ($urandom_range(0, 1) == 1) begin
                start_frame(1);
                put_bytes(fr.size());
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    f = crc_of_fr(0) ^ 32'h0000FFFF;
                    fr.push_back(f[7:0]); fr.push_back(f[15:8]);
                end
                start_frame(0);
                put_bytes(fr.size());
            end
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
